// File: rtl/slow_ctl.sv
// slow_ctl: requests stock-speed operation (and optionally fast-clock gating)
// around qualifying peripheral bus cycles, then holds the request for a
// programmable number of timebase ticks after the cycle ends.
module slow_ctl (
   input  logic       CLK,
   input  logic       nPOR,
   input  logic       BACT,
   input  logic       IACKCS,
   input  logic       VIACS,
   input  logic       IWMCS,
   input  logic       SCCCS,
   input  logic       SCSICS,
   input  logic       SndCSWR,
   input  logic       SlowIACK,
   input  logic       SlowVIA,
   input  logic       SlowIWM,
   input  logic       SlowSCC,
   input  logic       SlowSCSI,
   input  logic       SlowSnd,
   input  logic       SlowClockGate,
   input  logic [3:0] SlowTimeout,
   input  logic       TimerTick,
   output logic       Slow,
   output logic       ClockGateReq,
   output logic [3:0] SlowCnt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_slow;
   logic       r_cgr;
   logic       r_bactr;
   logic       r_armed;
   logic       w_hit;
   logic       w_start;

   // A qualifying access is any asserted select whose slowdown enable is set
   always_comb begin
      w_hit = (IACKCS  & SlowIACK) |
              (VIACS   & SlowVIA)  |
              (IWMCS   & SlowIWM)  |
              (SCCCS   & SlowSCC)  |
              (SCSICS  & SlowSCSI) |
              (SndCSWR & SlowSnd);
   end

   // r_armed blocks a Start from a bus cycle that straddled reset release:
   // BACT must be seen low once before a rising edge can count.
   assign w_start = BACT & ~r_bactr & r_armed & w_hit;

   // Bus-cycle edge detector and post-reset arming flag
   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         r_bactr <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_bactr <= BACT;
         if (!BACT) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Next-state and hold-count logic; a Start always wins over a tick
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_start) begin
         w_state_nxt = S_ACCESS;
         w_cnt_nxt   = SlowTimeout;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_cnt_nxt = '0;
            end
            S_ACCESS: begin
               if (!BACT) begin
                  if (r_cnt == 4'd0) begin
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_state_nxt = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (TimerTick) begin
                  if (r_cnt <= 4'd1) begin
                     w_state_nxt = S_IDLE;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt - 4'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, count and registered requests; outputs follow the next state
   always_ff @(posedge CLK) begin
      if (!nPOR) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_slow  <= 1'b0;
         r_cgr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_slow  <= (w_state_nxt != S_IDLE);
         r_cgr   <= (w_state_nxt != S_IDLE) & SlowClockGate;
      end
   end

   assign Slow         = r_slow;
   assign ClockGateReq = r_cgr;
   assign SlowCnt      = r_cnt;

endmodule

// File: tb/tb_slow_ctl.sv
// tb_slow_ctl: directed vectors with hand-computed expectations for slow_ctl.
module tb_slow_ctl;

   logic       CLK = 1'b0;
   logic       nPOR;
   logic       BACT;
   logic [5:0] r_cs;
   logic [5:0] r_en;
   logic       SlowClockGate;
   logic [3:0] SlowTimeout;
   logic       TimerTick;
   logic       Slow;
   logic       ClockGateReq;
   logic [3:0] SlowCnt;

   // bit order: 0 IACK, 1 VIA, 2 IWM, 3 SCC, 4 SCSI, 5 Snd
   localparam int unsigned B_IACK = 0;
   localparam int unsigned B_VIA  = 1;
   localparam int unsigned B_IWM  = 2;
   localparam int unsigned B_SCC  = 3;
   localparam int unsigned B_SCSI = 4;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   slow_ctl u_dut (
      .CLK          (CLK),
      .nPOR         (nPOR),
      .BACT         (BACT),
      .IACKCS       (r_cs[0]),
      .VIACS        (r_cs[1]),
      .IWMCS        (r_cs[2]),
      .SCCCS        (r_cs[3]),
      .SCSICS       (r_cs[4]),
      .SndCSWR      (r_cs[5]),
      .SlowIACK     (r_en[0]),
      .SlowVIA      (r_en[1]),
      .SlowIWM      (r_en[2]),
      .SlowSCC      (r_en[3]),
      .SlowSCSI     (r_en[4]),
      .SlowSnd      (r_en[5]),
      .SlowClockGate(SlowClockGate),
      .SlowTimeout  (SlowTimeout),
      .TimerTick    (TimerTick),
      .Slow         (Slow),
      .ClockGateReq (ClockGateReq),
      .SlowCnt      (SlowCnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // advance one clock; inputs set after return are sampled at the next edge
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_tick();
      TimerTick = 1'b1;
      cyc();
      TimerTick = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic slow, input logic cgr, input logic [3:0] cnt);
      chk({tag, ".slow"}, {31'd0, Slow}, {31'd0, slow});
      chk({tag, ".cgr"},  {31'd0, ClockGateReq}, {31'd0, cgr});
      chk({tag, ".cnt"},  {28'd0, SlowCnt}, {28'd0, cnt});
   endtask

   initial begin
      nPOR = 1'b0; BACT = 1'b0; r_cs = '0; r_en = '0;
      SlowClockGate = 1'b0; SlowTimeout = '0; TimerTick = 1'b0;
      cyc(); cyc();
      chk_out("reset", 1'b0, 1'b0, 4'd0);
      nPOR = 1'b1;
      cyc();

      // VIA access, timeout 3, ticks every 10 cycles
      r_en = 6'b1 << B_VIA; SlowTimeout = 4'd3; SlowClockGate = 1'b1;
      BACT = 1'b1; r_cs = 6'b1 << B_VIA;
      cyc();
      chk_out("via.start", 1'b1, 1'b1, 4'd3);
      cyc();
      TimerTick = 1'b1;           // ignored during ACCESS
      cyc();
      TimerTick = 1'b0;
      cyc();
      chk_out("via.access", 1'b1, 1'b1, 4'd3);
      BACT = 1'b0; r_cs = '0;
      cyc();
      chk_out("via.hold", 1'b1, 1'b1, 4'd3);
      SlowTimeout = 4'd9; r_en = '0;   // no effect until next Start
      for (int k = 1; k <= 3; k++) begin
         repeat (9) cyc();
         chk("via.pretick", {28'd0, SlowCnt}, 32'(4 - k));
         pulse_tick();
         chk("via.tickcnt", {28'd0, SlowCnt}, 32'(3 - k));
         chk("via.tickslow", {31'd0, Slow}, {31'd0, (k < 3)});
      end
      chk_out("via.done", 1'b0, 1'b0, 4'd0);

      // SCC access, timeout 0: slow only for the access
      r_en = 6'b1 << B_SCC; SlowTimeout = 4'd0; SlowClockGate = 1'b0;
      BACT = 1'b1; r_cs = 6'b1 << B_SCC;
      cyc();
      chk_out("scc.start", 1'b1, 1'b0, 4'd0);
      cyc();
      chk("scc.access", {31'd0, Slow}, 32'd1);
      BACT = 1'b0; r_cs = '0;
      cyc();
      chk_out("scc.end", 1'b0, 1'b0, 4'd0);

      // IWM access with its enable low
      r_en = 6'b111011; SlowTimeout = 4'd4;
      BACT = 1'b1; r_cs = 6'b1 << B_IWM;
      cyc();
      chk_out("iwm.off", 1'b0, 1'b0, 4'd0);
      cyc();
      BACT = 1'b0; r_cs = '0;
      cyc();

      // select asserted after BACT already high
      r_en = 6'b1 << B_VIA;
      BACT = 1'b1;
      cyc();
      r_cs = 6'b1 << B_VIA;
      cyc();
      chk_out("midcycle", 1'b0, 1'b0, 4'd0);
      BACT = 1'b0; r_cs = '0;
      cyc();

      // Start coincident with a tick while HOLD count is 1
      SlowTimeout = 4'd2;
      BACT = 1'b1; r_cs = 6'b1 << B_VIA;
      cyc();
      BACT = 1'b0; r_cs = '0;
      cyc();
      pulse_tick();
      chk_out("coinc.pre", 1'b1, 1'b0, 4'd1);
      SlowTimeout = 4'd5; BACT = 1'b1; r_cs = 6'b1 << B_VIA; TimerTick = 1'b1;
      cyc();
      TimerTick = 1'b0;
      chk_out("coinc.reload", 1'b1, 1'b0, 4'd5);
      pulse_tick();               // still ACCESS: tick ignored
      chk("coinc.access", {28'd0, SlowCnt}, 32'd5);
      BACT = 1'b0; r_cs = '0;
      cyc();
      chk_out("coinc.hold", 1'b1, 1'b0, 4'd5);

      // reset during HOLD with count 7, BACT held across release
      SlowTimeout = 4'd7;
      BACT = 1'b1; r_cs = 6'b1 << B_VIA;
      cyc();
      BACT = 1'b0; r_cs = '0;
      cyc();
      chk_out("rst.hold7", 1'b1, 1'b0, 4'd7);
      nPOR = 1'b0; BACT = 1'b1; r_cs = 6'b1 << B_VIA;
      cyc();
      chk_out("rst.abort", 1'b0, 1'b0, 4'd0);
      nPOR = 1'b1;
      cyc();
      chk_out("rst.nostart", 1'b0, 1'b0, 4'd0);
      cyc();
      chk("rst.nostart2", {31'd0, Slow}, 32'd0);
      BACT = 1'b0;
      cyc();
      BACT = 1'b1;
      cyc();
      chk_out("rst.restart", 1'b1, 1'b0, 4'd7);
      BACT = 1'b0; r_cs = '0;
      cyc();
      pulse_tick();
      chk("nq.pre", {28'd0, SlowCnt}, 32'd6);
      // non-qualifying access must not extend the hold
      BACT = 1'b1; r_cs = 6'b1 << B_IWM;
      cyc();
      chk_out("nq.noextend", 1'b1, 1'b0, 4'd6);
      BACT = 1'b0; r_cs = '0;
      cyc();
      repeat (5) pulse_tick();
      chk_out("nq.last", 1'b1, 1'b0, 4'd1);
      pulse_tick();
      chk_out("nq.done", 1'b0, 1'b0, 4'd0);

      // SCSI access with clock gating off, then on
      r_en = 6'b1 << B_SCSI; SlowTimeout = 4'd1; SlowClockGate = 1'b0;
      BACT = 1'b1; r_cs = 6'b1 << B_SCSI;
      cyc();
      chk_out("cg0.start", 1'b1, 1'b0, 4'd1);
      BACT = 1'b0; r_cs = '0;
      cyc();
      chk_out("cg0.hold", 1'b1, 1'b0, 4'd1);
      pulse_tick();
      chk_out("cg0.end", 1'b0, 1'b0, 4'd0);
      SlowClockGate = 1'b1;
      cyc();
      chk("cg1.idle", {31'd0, ClockGateReq}, 32'd0);
      BACT = 1'b1; r_cs = 6'b1 << B_SCSI;
      cyc();
      chk_out("cg1.start", 1'b1, 1'b1, 4'd1);
      BACT = 1'b0; r_cs = '0;
      cyc();
      chk_out("cg1.hold", 1'b1, 1'b1, 4'd1);
      pulse_tick();
      chk_out("cg1.end", 1'b0, 1'b0, 4'd0);

      // every source with its own enable, then with a neighbour's enable
      SlowTimeout = 4'd0; SlowClockGate = 1'b0;
      for (int i = 0; i < 6; i++) begin
         r_en = 6'b1 << i;
         BACT = 1'b1; r_cs = 6'b1 << i;
         cyc();
         chk($sformatf("src%0d.hit", i), {31'd0, Slow}, 32'd1);
         BACT = 1'b0; r_cs = '0;
         cyc();
         chk($sformatf("src%0d.end", i), {31'd0, Slow}, 32'd0);
         BACT = 1'b1; r_cs = 6'b1 << ((i + 1) % 6);
         cyc();
         chk($sformatf("src%0d.miss", i), {31'd0, Slow}, 32'd0);
         BACT = 1'b0; r_cs = '0;
         cyc();
      end
      r_en[B_IACK] = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
